// File: rtl/maria_line_buffer.sv
// Ping-pong line buffer between the MARIA renderer and the VGA scan-out.
// Each source line is shown on two VGA rows. Banks swap in hblank after the odd row of a pair.
`timescale 1ns/1ps
module maria_line_buffer #(
  parameter int unsigned PIXELS = 320,
  parameter int unsigned LINES  = 240,
  parameter int unsigned PIXW   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [9:0]                   line_number,
  input  logic                         outputting,
  output logic                         line_req,
  output logic [7:0]                   req_line,
  input  logic                         wr_en,
  input  logic [8:0]                   wr_addr,
  input  logic [PIXW-1:0]              wr_data,
  input  logic                         wr_done,
  output logic [PIXELS-1:0][PIXW-1:0]  lbuffer,
  output logic                         underrun
);

  typedef enum logic {StFill, StReady} state_e;

  state_e                      state_q, state_d;
  logic [PIXELS-1:0][PIXW-1:0] bank_a_q, bank_b_q;
  logic                        front_b_q;  // 1: bank B is the front (displayed) bank
  logic                        prev_outputting_q;
  logic                        first_q;
  logic                        line_req_q;
  logic                        underrun_q;
  logic [7:0]                  req_line_q, req_line_d;
  logic                        swap_event, do_swap, do_underrun;
  logic                        wr_ok, we_a, we_b;

  // Falling edge of active video on an odd row marks column 640 of that row.
  assign swap_event = prev_outputting_q & ~outputting & line_number[0] &
                      (line_number < 10'(2 * LINES));

  assign wr_ok = (state_q == StFill) & wr_en & (32'(wr_addr) < PIXELS);
  assign we_a  = wr_ok & front_b_q;
  assign we_b  = wr_ok & ~front_b_q;

  always_comb begin
    state_d     = state_q;
    req_line_d  = req_line_q;
    do_swap     = 1'b0;
    do_underrun = 1'b0;
    if (swap_event) begin
      req_line_d = (req_line_q == 8'(LINES - 1)) ? 8'd0 : req_line_q + 8'd1;
      state_d    = StFill;
      // A wr_done landing on the swap cycle still counts as a completed line.
      if ((state_q == StReady) || wr_done) begin
        do_swap = 1'b1;
      end else begin
        do_underrun = 1'b1;
      end
    end else if ((state_q == StFill) && wr_done) begin
      state_d = StReady;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= StFill;
      req_line_q        <= 8'd1;
      front_b_q         <= 1'b0;
      prev_outputting_q <= 1'b0;
      first_q           <= 1'b1;
      line_req_q        <= 1'b0;
      underrun_q        <= 1'b0;
    end else begin
      state_q           <= state_d;
      req_line_q        <= req_line_d;
      front_b_q         <= front_b_q ^ do_swap;
      prev_outputting_q <= outputting;
      first_q           <= 1'b0;
      line_req_q        <= first_q | swap_event;
      underrun_q        <= underrun_q | do_underrun;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_a_q <= '0;
      bank_b_q <= '0;
    end else begin
      if (we_a) bank_a_q[wr_addr] <= wr_data;
      if (we_b) bank_b_q[wr_addr] <= wr_data;
    end
  end

  assign lbuffer  = front_b_q ? bank_b_q : bank_a_q;
  assign line_req = line_req_q;
  assign req_line = req_line_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_maria_line_buffer.sv
// Directed bench for maria_line_buffer; line requests are checked by a queue-based monitor.
`timescale 1ns/1ps
module tb_maria_line_buffer;
  localparam int PIXELS = 320;
  localparam int LINES  = 240;
  localparam int PIXW   = 8;

  logic                        clk = 1'b0;
  logic                        reset = 1'b1;
  logic [9:0]                  line_number = '0;
  logic                        outputting = 1'b0;
  logic                        line_req;
  logic [7:0]                  req_line;
  logic                        wr_en = 1'b0;
  logic [8:0]                  wr_addr = '0;
  logic [PIXW-1:0]             wr_data = '0;
  logic                        wr_done = 1'b0;
  logic [PIXELS-1:0][PIXW-1:0] lbuffer;
  logic                        underrun;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  logic [PIXELS-1:0][PIXW-1:0] exp_front = '0;

  maria_line_buffer #(.PIXELS(PIXELS), .LINES(LINES), .PIXW(PIXW)) dut (
    .clk         (clk),
    .reset       (reset),
    .line_number (line_number),
    .outputting  (outputting),
    .line_req    (line_req),
    .req_line    (req_line),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_done     (wr_done),
    .lbuffer     (lbuffer),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  // Monitor: every line_req pulse must match the next queued request.
  always @(negedge clk) begin
    if (line_req === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL line_req: unexpected pulse, req_line=%0d, none expected", req_line);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (req_line !== 8'(e)) begin
          n_err++;
          $display("FAIL req_line: got %0d expected %0d", req_line, e);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_front(input string name);
    n_cmp++;
    if (lbuffer !== exp_front) begin
      n_err++;
      for (int c = 0; c < PIXELS; c++) begin
        if (lbuffer[c] !== exp_front[c]) begin
          $display("FAIL %s: col %0d got %0h expected %0h", name, c, lbuffer[c], exp_front[c]);
          break;
        end
      end
    end
  endtask

  task automatic wr(input int addr, input int data);
    wr_en   = 1'b1;
    wr_addr = 9'(addr);
    wr_data = 8'(data);
    step();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_done();
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
  endtask

  // Compressed VGA row: active video, then the falling edge of outputting.
  task automatic row(input int r, input bit done_at_edge);
    line_number = 10'(r);
    outputting  = 1'b1;
    step();
    step();
    outputting  = 1'b0;
    wr_done     = done_at_edge;
    chk_front("pre_edge_front");
    step();
    wr_done     = 1'b0;
    step();
  endtask

  initial begin
    int cur;
    // 1. Reset and release
    exp_q.push_back(1);
    step();
    step();
    reset = 1'b0;
    step();
    step();
    chk_front("reset_front");
    chk("reset_underrun", underrun, 0);

    // 2. Fill line 1, out-of-range write, wr_done, ignored write in READY, swap at row 1
    for (int c = 0; c < PIXELS; c++) wr(c, c);
    wr(320, 8'hFF);
    pulse_done();
    wr(5, 8'hAA);
    exp_q.push_back(2);
    row(0, 1'b0);
    row(1, 1'b0);
    for (int c = 0; c < PIXELS; c++) exp_front[c] = 8'(c);
    chk_front("swap_row1_front");
    chk("col5_ready_write_ignored", lbuffer[5], 8'd5);
    chk("underrun_after_row1", underrun, 0);

    // 3. No wr_done before row-3 swap point: underrun
    exp_q.push_back(3);
    row(2, 1'b0);
    row(3, 1'b0);
    chk_front("underrun_front_kept");
    chk("underrun_set", underrun, 1);

    // 5. wr_done coincident with swap event: swap happens
    wr(0, 8'h11);
    exp_q.push_back(4);
    row(4, 1'b0);
    row(5, 1'b1);
    exp_front = '0;
    exp_front[0] = 8'h11;
    chk_front("done_at_swap_front");
    chk("underrun_sticky", underrun, 1);

    // 6. Reset mid-fill at column 100
    for (int c = 0; c < 100; c++) wr(c, 8'h80 | c);
    wr_en   = 1'b1;
    wr_addr = 9'd100;
    wr_data = 8'h55;
    reset   = 1'b1;
    #1;
    wr_en = 1'b0;
    exp_front = '0;
    chk_front("midreset_front");
    chk("midreset_underrun", underrun, 0);
    chk("midreset_req_line", req_line, 1);
    chk("midreset_line_req", line_req, 0);
    exp_q.push_back(1);
    step();
    step();
    reset = 1'b0;
    step();
    step();

    // 4. Full frame: requests 1..239, 0, then 1
    cur = 1;
    for (int k = 0; k < LINES; k++) begin
      wr(0, cur);
      pulse_done();
      exp_q.push_back((cur + 1) % LINES);
      row(2 * k, 1'b0);
      row(2 * k + 1, 1'b0);
      exp_front = '0;
      exp_front[0] = 8'(cur);
      chk_front("frame_front");
      cur = (cur + 1) % LINES;
    end
    chk("frame_underrun", underrun, 0);

    repeat (3) step();
    chk("requests_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
